// File: rtl/mem_io_subsystem.sv
// Memory and I/O subsystem: one dual-port RAM (read-only fetch port, read/write data port)
// plus a memory-mapped I/O window with LEDs, seven-segment digits, switches, keys and a cycle counter.
module mem_io_subsystem #(
  parameter int ADDR_W    = 11,
  parameter int DATA_W    = 32,
  parameter int MEM_DEPTH = 1024,
  parameter int NUM_HEX   = 6,
  parameter int LED_W     = 10,
  parameter int SW_W      = 10,
  parameter int KEY_W     = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [ADDR_W-1:0]    i_addr,
  output logic [DATA_W-1:0]    i_rdata,
  input  logic [ADDR_W-1:0]    d_addr,
  input  logic [DATA_W-1:0]    d_wdata,
  input  logic                 d_wen,
  input  logic                 d_ren,
  output logic [DATA_W-1:0]    d_rdata,
  output logic                 d_valid,
  output logic                 d_err,
  input  logic [SW_W-1:0]      sw,
  input  logic [KEY_W-1:0]     key,
  output logic [LED_W-1:0]     ledr,
  output logic [7*NUM_HEX-1:0] hex
);

  localparam int RAM_AW = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
  localparam logic [ADDR_W-1:0] DEPTH_L = ADDR_W'(MEM_DEPTH);

  logic [DATA_W-1:0] mem [MEM_DEPTH];

  logic [ADDR_W-2:0] i_off;
  logic [ADDR_W-2:0] d_off;
  logic [RAM_AW-1:0] i_idx;
  logic [RAM_AW-1:0] d_idx;
  logic [3:0]        io_off;
  logic              i_ram_ok;
  logic              d_io;
  logic              d_ram_ok;
  logic              d_rd_ok;
  logic              d_wr_ok;
  logic              ram_we;
  logic              ram_re;

  logic [DATA_W-1:0] io_rd;
  logic              io_rd_ok;
  logic              io_wr_ok;

  logic [LED_W-1:0]  led_q;
  logic [4:0]        hex_q [NUM_HEX];
  logic [DATA_W-1:0] cnt_q;
  logic [SW_W-1:0]   sw_s1;
  logic [SW_W-1:0]   sw_s2;
  logic [KEY_W-1:0]  key_s1;
  logic [KEY_W-1:0]  key_s2;

  logic [DATA_W-1:0] i_ram_q;
  logic [DATA_W-1:0] d_ram_q;
  logic [DATA_W-1:0] d_io_q;
  logic              i_sel_ram;
  logic              d_sel_ram;

  assign i_off    = i_addr[ADDR_W-2:0];
  assign d_off    = d_addr[ADDR_W-2:0];
  assign i_idx    = i_off[RAM_AW-1:0];
  assign d_idx    = d_off[RAM_AW-1:0];
  assign io_off   = d_addr[3:0];
  assign d_io     = d_addr[ADDR_W-1];
  assign i_ram_ok = !i_addr[ADDR_W-1] && ({1'b0, i_off} < DEPTH_L);
  assign d_ram_ok = !d_io && ({1'b0, d_off} < DEPTH_L);

  always_comb begin
    io_rd    = '0;
    io_rd_ok = 1'b0;
    io_wr_ok = 1'b0;
    if (io_off == 4'd0) begin
      io_rd    = DATA_W'(led_q);
      io_rd_ok = 1'b1;
      io_wr_ok = 1'b1;
    end
    for (int n = 0; n < NUM_HEX; n++) begin
      if (io_off == 4'(n + 1)) begin
        io_rd    = DATA_W'(hex_q[n]);
        io_rd_ok = 1'b1;
        io_wr_ok = 1'b1;
      end
    end
    if (io_off == 4'd8) begin
      io_rd    = DATA_W'(sw_s2);
      io_rd_ok = 1'b1;
    end
    if (io_off == 4'd9) begin
      io_rd    = DATA_W'(key_s2);
      io_rd_ok = 1'b1;
    end
    if (io_off == 4'd10) begin
      io_rd    = cnt_q;
      io_rd_ok = 1'b1;
      io_wr_ok = 1'b1;
    end
  end

  assign d_rd_ok = d_ram_ok || (d_io && io_rd_ok);
  assign d_wr_ok = d_ram_ok || (d_io && io_wr_ok);
  // A simultaneous store and load is a store; nothing reaches the RAM while in reset.
  assign ram_we  = rst_n && d_wen && d_ram_ok;
  assign ram_re  = rst_n && d_ren && !d_wen && d_ram_ok;

  // Fetch reads the old word on a same-address store (read-before-write).
  always_ff @(posedge clk) begin
    if (ram_we) mem[d_idx] <= d_wdata;
    i_ram_q <= mem[i_idx];
    if (ram_re) d_ram_q <= mem[d_idx];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      led_q     <= '0;
      for (int n = 0; n < NUM_HEX; n++) hex_q[n] <= '0;
      cnt_q     <= '0;
      sw_s1     <= '0;
      sw_s2     <= '0;
      key_s1    <= '0;
      key_s2    <= '0;
      d_valid   <= 1'b0;
      d_err     <= 1'b0;
      d_sel_ram <= 1'b0;
      d_io_q    <= '0;
      i_sel_ram <= 1'b0;
    end else begin
      sw_s1     <= sw;
      sw_s2     <= sw_s1;
      key_s1    <= ~key;
      key_s2    <= key_s1;
      i_sel_ram <= i_ram_ok;
      d_valid   <= 1'b0;
      d_err     <= 1'b0;
      cnt_q     <= cnt_q + DATA_W'(1);
      if (d_wen) begin
        if (!d_wr_ok) begin
          d_err <= 1'b1;
        end else if (d_io) begin
          if (io_off == 4'd0) led_q <= d_wdata[LED_W-1:0];
          for (int n = 0; n < NUM_HEX; n++) begin
            if (io_off == 4'(n + 1)) hex_q[n] <= d_wdata[4:0];
          end
          if (io_off == 4'd10) cnt_q <= d_wdata;
        end
      end else if (d_ren) begin
        d_valid   <= 1'b1;
        d_err     <= !d_rd_ok;
        d_sel_ram <= d_ram_ok;
        d_io_q    <= (d_io && io_rd_ok) ? io_rd : '0;
      end
    end
  end

  assign i_rdata = i_sel_ram ? i_ram_q : '0;
  assign d_rdata = d_sel_ram ? d_ram_q : d_io_q;
  assign ledr    = led_q;

  function automatic logic [6:0] seg7(input logic [3:0] v);
    case (v)
      4'h0:    seg7 = 7'h40;
      4'h1:    seg7 = 7'h79;
      4'h2:    seg7 = 7'h24;
      4'h3:    seg7 = 7'h30;
      4'h4:    seg7 = 7'h19;
      4'h5:    seg7 = 7'h12;
      4'h6:    seg7 = 7'h02;
      4'h7:    seg7 = 7'h78;
      4'h8:    seg7 = 7'h00;
      4'h9:    seg7 = 7'h10;
      4'hA:    seg7 = 7'h08;
      4'hB:    seg7 = 7'h03;
      4'hC:    seg7 = 7'h46;
      4'hD:    seg7 = 7'h21;
      4'hE:    seg7 = 7'h06;
      default: seg7 = 7'h0E;
    endcase
  endfunction

  for (genvar n = 0; n < NUM_HEX; n++) begin : g_hex
    assign hex[7*n +: 7] = hex_q[n][4] ? seg7(hex_q[n][3:0]) : 7'h7F;
  end

endmodule

// File: tb/tb_mem_io_subsystem.sv
// Directed bench for mem_io_subsystem: stimulus pushes expected responses into queues,
// a negedge monitor pops and compares whenever the DUT answers.
module tb_mem_io_subsystem;

  localparam logic [10:0] IO = 11'h400;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [10:0] i_addr;
  logic [31:0] i_rdata;
  logic [10:0] d_addr;
  logic [31:0] d_wdata;
  logic        d_wen;
  logic        d_ren;
  logic [31:0] d_rdata;
  logic        d_valid;
  logic        d_err;
  logic [9:0]  sw;
  logic [3:0]  key;
  logic [9:0]  ledr;
  logic [41:0] hex;

  always #5 clk = ~clk;

  mem_io_subsystem dut (
    .clk(clk), .rst_n(rst_n),
    .i_addr(i_addr), .i_rdata(i_rdata),
    .d_addr(d_addr), .d_wdata(d_wdata), .d_wen(d_wen), .d_ren(d_ren),
    .d_rdata(d_rdata), .d_valid(d_valid), .d_err(d_err),
    .sw(sw), .key(key), .ledr(ledr), .hex(hex)
  );

  typedef struct {
    int          due;
    logic        valid;
    logic        err;
    logic [31:0] data;
  } d_exp_t;

  typedef struct {
    int          due;
    logic [31:0] data;
  } i_exp_t;

  d_exp_t dq[$];
  i_exp_t iq[$];
  d_exp_t de;
  i_exp_t ie;
  int     n_vec = 0;
  int     n_bad = 0;
  int     cyc   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    while (dq.size() > 0 && dq[0].due < cyc) begin
      de = dq.pop_front();
      n_vec++;
      n_bad++;
      $display("FAIL d_resp_missing: no response at cycle %0d, required valid=%0b err=%0b data=%h",
               de.due, de.valid, de.err, de.data);
    end
    if (d_valid === 1'b1 || d_err === 1'b1) begin
      n_vec++;
      if (dq.size() == 0 || dq[0].due != cyc) begin
        n_bad++;
        $display("FAIL d_resp_unexpected: got valid=%0b err=%0b data=%h at cycle %0d, required no response",
                 d_valid, d_err, d_rdata, cyc);
      end else begin
        de = dq.pop_front();
        if (d_valid !== de.valid || d_err !== de.err || (de.valid && d_rdata !== de.data)) begin
          n_bad++;
          $display("FAIL d_resp cycle %0d: got valid=%0b err=%0b data=%h, required valid=%0b err=%0b data=%h",
                   cyc, d_valid, d_err, d_rdata, de.valid, de.err, de.data);
        end
      end
    end
    while (iq.size() > 0 && iq[0].due <= cyc) begin
      ie = iq.pop_front();
      n_vec++;
      if (ie.due != cyc || i_rdata !== ie.data) begin
        n_bad++;
        $display("FAIL i_rdata cycle %0d: got %h, required %h (due cycle %0d)", cyc, i_rdata, ie.data, ie.due);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h, required %h", nm, act, exp);
    end
  endtask

  task automatic load(input logic [10:0] a, input logic [31:0] exp, input logic err);
    d_addr = a;
    d_wen  = 1'b0;
    d_ren  = 1'b1;
    dq.push_back('{cyc + 1, 1'b1, err, exp});
    step();
    d_ren = 1'b0;
  endtask

  task automatic store(input logic [10:0] a, input logic [31:0] w, input logic err);
    d_addr  = a;
    d_wdata = w;
    d_wen   = 1'b1;
    d_ren   = 1'b0;
    if (err) dq.push_back('{cyc + 1, 1'b0, 1'b1, 32'h0});
    step();
    d_wen = 1'b0;
  endtask

  task automatic fetch(input logic [10:0] a, input logic [31:0] exp);
    i_addr = a;
    iq.push_back('{cyc + 1, exp});
  endtask

  task automatic summary();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
  endtask

  initial begin
    #200000;
    n_bad++;
    $display("FAIL watchdog: simulation did not complete, required completion before 200000");
    summary();
    $fatal(1, "watchdog expired");
  end

  initial begin
    // A store to the LED register held throughout reset must be discarded.
    rst_n   = 1'b0;
    i_addr  = '0;
    d_addr  = IO | 11'd0;
    d_wdata = 32'h3FF;
    d_wen   = 1'b1;
    d_ren   = 1'b0;
    sw      = '0;
    key     = 4'hF;
    step(); step(); step();
    chk("rst_i_rdata", i_rdata, 32'h0);
    chk("rst_d_rdata", d_rdata, 32'h0);
    chk("rst_d_valid", 32'(d_valid), 32'h0);
    chk("rst_d_err", 32'(d_err), 32'h0);
    chk("rst_ledr", 32'(ledr), 32'h0);
    for (int n = 0; n < 6; n++) chk("rst_hex", 32'(hex[7*n +: 7]), 32'h7F);

    d_wen = 1'b0;
    rst_n = 1'b1;
    step();
    chk("post_rst_ledr", 32'(ledr), 32'h0);
    chk("post_rst_d_valid", 32'(d_valid), 32'h0);
    chk("post_rst_hex_blank", 32'(hex[41:21]), 32'h1FFFFF);
    chk("post_rst_hex_blank_lo", 32'(hex[20:0]), 32'h1FFFFF);
    load(IO | 11'd10, 32'd1, 1'b0);

    store(11'd5, 32'hDEADBEEF, 1'b0);
    fetch(11'd5, 32'hDEADBEEF);
    load(11'd5, 32'hDEADBEEF, 1'b0);
    step();
    chk("d_rdata_hold", d_rdata, 32'hDEADBEEF);

    store(11'd7, 32'h11111111, 1'b0);
    fetch(11'd7, 32'h11111111);
    store(11'd7, 32'h22222222, 1'b0);
    fetch(11'd7, 32'h22222222);
    step();
    load(11'd7, 32'h22222222, 1'b0);

    d_addr  = 11'd9;
    d_wdata = 32'hCAFEF00D;
    d_wen   = 1'b1;
    d_ren   = 1'b1;
    step();
    d_wen = 1'b0;
    d_ren = 1'b0;
    load(11'd9, 32'hCAFEF00D, 1'b0);

    store(IO | 11'd0, 32'h2AA, 1'b0);
    chk("ledr_write", 32'(ledr), 32'h2AA);
    load(IO | 11'd0, 32'h2AA, 1'b0);
    store(IO | 11'd1, 32'h13, 1'b0);
    chk("hex0_3", 32'(hex[6:0]), 32'h30);
    store(IO | 11'd2, 32'h03, 1'b0);
    chk("hex1_disabled", 32'(hex[13:7]), 32'h7F);
    load(IO | 11'd2, 32'h03, 1'b0);
    store(IO | 11'd3, 32'hFFFFFF18, 1'b0);
    chk("hex2_8", 32'(hex[20:14]), 32'h00);
    load(IO | 11'd3, 32'h18, 1'b0);
    store(IO | 11'd4, 32'h10, 1'b0);
    chk("hex3_0", 32'(hex[27:21]), 32'h40);
    store(IO | 11'd5, 32'h11, 1'b0);
    chk("hex4_1", 32'(hex[34:28]), 32'h79);
    store(IO | 11'd6, 32'h1F, 1'b0);
    chk("hex5_F", 32'(hex[41:35]), 32'h0E);

    load(11'h5DC, 32'h0, 1'b1);
    store(IO | 11'd8, 32'h3FF, 1'b1);
    chk("ro_store_ledr", 32'(ledr), 32'h2AA);
    load(IO | 11'd8, 32'h0, 1'b0);
    store(IO | 11'd7, 32'h1F, 1'b1);
    load(IO | 11'd7, 32'h0, 1'b1);
    load(IO | 11'd15, 32'h0, 1'b1);
    store(IO | 11'd12, 32'h1, 1'b1);
    chk("err_hold_d_rdata", d_rdata, 32'h0);

    sw = 10'h155;
    step(); step();
    load(IO | 11'd8, 32'h155, 1'b0);
    sw = 10'h0AA;
    step();
    load(IO | 11'd8, 32'h155, 1'b0);
    load(IO | 11'd8, 32'h0AA, 1'b0);
    key = 4'b1010;
    step(); step();
    load(IO | 11'd9, 32'h5, 1'b0);

    store(IO | 11'd10, 32'hFFFFFFFF, 1'b0);
    step();
    load(IO | 11'd10, 32'h0, 1'b0);
    store(IO | 11'd10, 32'h100, 1'b0);
    load(IO | 11'd10, 32'h100, 1'b0);
    load(IO | 11'd10, 32'h101, 1'b0);

    rst_n  = 1'b0;
    d_addr = IO | 11'd0;
    d_ren  = 1'b1;
    step();
    d_ren = 1'b0;
    chk("midrst_d_valid", 32'(d_valid), 32'h0);
    chk("midrst_d_err", 32'(d_err), 32'h0);
    chk("midrst_d_rdata", d_rdata, 32'h0);
    chk("midrst_ledr", 32'(ledr), 32'h0);
    rst_n = 1'b1;
    step(); step(); step();

    chk("d_queue_drained", 32'(dq.size()), 32'h0);
    chk("i_queue_drained", 32'(iq.size()), 32'h0);
    summary();
    $finish;
  end

endmodule
